// File: rtl/us_timer_arbiter.sv
// Shares one microsecond interval timer among NUM_REQ requesters with round-robin grant,
// counts us ticks for the owner, and pulses done on expiry or aborted on an early release.
module us_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     us_tick_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*DUR_W-1:0] dur_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     aborted_o,
    output logic                     busy_o,
    output logic [DUR_W-1:0]         elapsed_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [DUR_W-1:0] dur_lat_q, dur_lat_d;
    logic [DUR_W-1:0] elapsed_q, elapsed_d;
    logic             aborted_q, aborted_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [NUM_REQ-1:0] owner_oh;
    int               cand;

    // Round-robin search starts just after the previous owner and wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_q) + i) % NUM_REQ;
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        dur_lat_d = dur_lat_q;
        elapsed_d = elapsed_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d     = pick_idx;
                    dur_lat_d = dur_i[int'(pick_idx)*DUR_W +: DUR_W];
                    elapsed_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Abort outranks expiry; a tick in an exit cycle is dropped.
                if (!req_i[idx_q]) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    last_d    = idx_q;
                end else if (elapsed_q == dur_lat_q) begin
                    state_d = S_DONE;
                end else if (us_tick_i) begin
                    elapsed_d = elapsed_q + DUR_W'(1);
                end
            end
            S_DONE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            dur_lat_q <= '0;
            elapsed_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            dur_lat_q <= dur_lat_d;
            elapsed_q <= elapsed_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        grant_o   = (state_q == S_RUN)  ? owner_oh : '0;
        done_o    = (state_q == S_DONE) ? owner_oh : '0;
        busy_o    = (state_q == S_RUN) || (state_q == S_DONE);
        aborted_o = aborted_q;
        elapsed_o = elapsed_q;
    end

endmodule
